debounce: RTL and testbench

Parameterised multi-bit input conditioner: synchronises raw asynchronous inputs (switches, buttons) to `clk` and filters out bounce before they drive downstream combinational gates such as the two-input AND stage. Each bit is treated independently. A bit's filtered output changes only after its synchronised input has differed from the current output for a programmable number of consecutive cycles. Optional single-cycle edge pulses report each accepted transition.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_cell.sv | 91 +++++++++
 rtl/debounce.sv | 33 +++
 tb/tb_debounce.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the debounce input conditioner.
package debounce_pkg;

    // Default number of consecutive differing cycles needed to accept a change.
    localparam int DEF_CNT_MAX     = 1000;
    // Default synchroniser depth (two flops is the usual metastability guard).
    localparam int DEF_SYNC_STAGES = 2;

    // Counter width for a given CNT_MAX. The counter only ever holds 0..CNT_MAX-1.
    // It is never narrower than one bit.
    function automatic int cnt_w(input int cnt_max);
        return (cnt_max <= 1) ? 1 : $clog2(cnt_max);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-channel debounce cell: synchroniser chain, stability counter,
// filtered output level and optional edge pulses.
// Optional feature: define DEBOUNCE_EDGE_EN to build the rise/fall pulse
// registers; otherwise rise/fall are tied low.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int CNT_MAX     = DEF_CNT_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_w(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   s;
    logic                   accept;

    // Synchronised input and the condition for accepting a new level:
    // the input has differed from the output for CNT_MAX consecutive edges.
    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != dout_q) && (cnt_q == CNT_LAST);

    // Next-state: shift the synchroniser, count while the input differs,
    // drop any partial count as soon as the input agrees again.
    // NOTE: every variable gets a default at the top so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d  = '0;
        dout_d = dout_q;
        if (accept) begin
            dout_d = s;
        end else if (s != dout_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset is asynchronous so outputs clear without a clock.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Edge pulses fire on the same edge the output level is accepted.
    always_comb begin
        rise_d = accept & s;
        fall_d = accept & ~s;
    end

    // Edge pulse registers, one cycle wide by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/debounce.sv
// Multi-bit debounce: WIDTH independent debounce cells, one per input bit.
// Optional feature: define DEBOUNCE_EDGE_EN to enable the rise/fall pulses;
// otherwise they are constant 0. The dout behaviour is the same either way.
module debounce
    import debounce_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int CNT_MAX     = DEF_CNT_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_cell #(
            .CNT_MAX    (CNT_MAX),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .din (din[i]),
            .dout(dout[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with WIDTH=2, CNT_MAX=4, SYNC_STAGES=2
// (an accepted change appears 6 edges after din first changes).
module tb_debounce;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] din = 2'b00;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;

    int total = 0;
    int bad   = 0;

    debounce #(
        .WIDTH      (2),
        .CNT_MAX    (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .dout(dout),
        .rise(rise),
        .fall(fall)
    );

    always #5 clk = ~clk;

    // Edge pulses are only expected when the pulse registers are built.
    function automatic logic [1:0] ep(input logic [1:0] v);
        return EDGE_EN ? v : 2'b00;
    endfunction

    // Advance past one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] exp_dout,
                         input logic [1:0] exp_rise, input logic [1:0] exp_fall);
        logic [1:0] er;
        logic [1:0] ef;
        er = ep(exp_rise);
        ef = ep(exp_fall);
        total++;
        assert ({dout, rise, fall} === {exp_dout, er, ef}) else begin
            bad++;
            $error("FAIL %s: dout/rise/fall got %b/%b/%b expected %b/%b/%b",
                   tag, dout, rise, fall, exp_dout, er, ef);
        end
    endtask

    initial begin
        // Reset held with din toggling: everything stays 0.
        for (int i = 0; i < 6; i++) begin
            din = 2'(i);
            tick();
            check("reset_hold", 2'b00, 2'b00, 2'b00);
        end
        din = 2'b00;
        tick();
        #3 rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("post_reset", 2'b00, 2'b00, 2'b00);
        end

        // Clean rise then clean fall on channel 0.
        din = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("clean_rise", (k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end
        din = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("clean_fall", (k >= 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00);
        end

        // Three-cycle pulse is rejected.
        din = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) din = 2'b00;
            check("bounce3", 2'b00, 2'b00, 2'b00);
        end

        // Four-cycle pulse is accepted and reproduced as a four-cycle output.
        din = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) din = 2'b00;
            check("bounce4", (k >= 6 && k <= 9) ? 2'b01 : 2'b00,
                  (k == 6) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00);
        end

        // Both channels change on the same edge.
        din = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("both_rise", (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00);
        end

        // Two-cycle glitch on channel 1 only leaves both outputs alone.
        din = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) din = 2'b11;
            check("glitch1", 2'b11, 2'b00, 2'b00);
        end

        din = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("both_fall", (k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00);
        end

        // Establish dout[1]=1 so the asynchronous reset has something to clear.
        din = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("pre_rst", (k >= 6) ? 2'b10 : 2'b00, (k == 6) ? 2'b10 : 2'b00, 2'b00);
        end

        // Channel 0 mid-count when reset arrives between clock edges.
        din = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("count_before_rst", 2'b10, 2'b00, 2'b00);
        end
        #2 rst = 1'b1;
        #1 check("rst_async", 2'b00, 2'b00, 2'b00);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check("rst_held", 2'b00, 2'b00, 2'b00);
        end
        #3 rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("after_rst", (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
